// File: rtl/out_packet_arbiter_if.sv
// Packet bus between the arbiter and the serial sender.
// Handshake: the arbiter (master) raises pkt_valid with pkt_data held
// stable until a rising edge on which pkt_ready is also high; that edge
// transfers the packet. pkt_valid never drops before the transfer, and
// pkt_ready may be asserted independently of pkt_valid.
interface out_packet_arbiter_if;
    logic [39:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready;

    modport master (
        output pkt_data,
        output pkt_valid,
        input  pkt_ready
    );

    modport slave (
        input  pkt_data,
        input  pkt_valid,
        output pkt_ready
    );
endinterface

// File: rtl/out_packet_arbiter.sv
// Output packet arbiter: merges power-on replies, audio sample requests
// and keyboard/mouse events into one packet stream toward a serial
// sender, with a fixed idle gap after every accepted packet.
// Optional feature: audio request handling, compiled only when the
// macro OUT_ARB_AUDIO_REQ_EN is defined.
module out_packet_arbiter #(
    parameter int GAP = 16
) (
    input  logic                        mon_clk,
    input  logic                        reset_n,
    input  logic                        power_on_req,
    input  logic                        kb_valid,
    input  logic                        kb_is_mouse,
    input  logic [15:0]                 kb_data,
    input  logic                        audio_req_mode,
    input  logic                        audio_req_tick,
    out_packet_arbiter_if.master        pkt_if,
    output logic                        data_loss,
    output logic                        busy,
    output logic [1:0]                  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_PWR = 2'd0,
        SRC_AUD = 2'd1,
        SRC_KB  = 2'd2
    } src_t;

    localparam logic [7:0] LP_GAP = 8'(GAP);

    state_t      r_state;
    state_t      w_next_state;
    src_t        r_sel;
    src_t        w_sel_next;
    logic [39:0] r_pkt_data;
    logic [39:0] w_pkt_next;
    logic [7:0]  r_gap_cnt;
    logic [7:0]  w_gap_next;
    logic        w_done;

    logic        r_pwr_pend;
    logic        r_data_loss;

    // FIFO entry layout: {is_mouse, payload}; entry 0 is always the head.
    logic [16:0] r_fifo [2];
    logic [1:0]  r_fifo_cnt;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_wr_idx;
    logic [39:0] w_kb_pkt;

    assign w_fifo_full  = (r_fifo_cnt == 2'd2);
    assign w_fifo_empty = (r_fifo_cnt == 2'd0);
    assign w_pop        = w_done && (r_sel == SRC_KB);
    // A push into a full FIFO is allowed only when the head leaves on the same edge.
    assign w_push       = kb_valid && (!w_fifo_full || w_pop);
    // Slot for the new entry after any simultaneous pop shifts the head out.
    assign w_wr_idx     = w_fifo_full || ((r_fifo_cnt == 2'd1) && !w_pop);
    assign w_kb_pkt     = {(r_fifo[0][16] ? 8'hDB : 8'hDA), 16'h0000, r_fifo[0][15:0]};

`ifdef OUT_ARB_AUDIO_REQ_EN
    logic r_aud_pend;
    logic w_aud_offered;

    assign w_aud_offered = (r_state == ST_OFFER) && (r_sel == SRC_AUD);

    // Audio pending flag: ticks coalesce; leaving audio mode cancels a request not yet offered.
    always_ff @(posedge mon_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_aud_pend <= 1'b0;
        end else if (audio_req_tick && audio_req_mode) begin
            r_aud_pend <= 1'b1;
        end else if (w_done && (r_sel == SRC_AUD)) begin
            r_aud_pend <= 1'b0;
        end else if (!audio_req_mode && !w_aud_offered) begin
            r_aud_pend <= 1'b0;
        end
    end
`else
    logic w_unused_audio;
    assign w_unused_audio = audio_req_mode ^ audio_req_tick;
`endif

    // Power-on pending flag: repeated pulses coalesce; a new pulse outranks the clear.
    always_ff @(posedge mon_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwr_pend <= 1'b0;
        end else if (power_on_req) begin
            r_pwr_pend <= 1'b1;
        end else if (w_done && (r_sel == SRC_PWR)) begin
            r_pwr_pend <= 1'b0;
        end
    end

    // Two-entry keyboard/mouse FIFO with shift-on-pop and overflow detection.
    always_ff @(posedge mon_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_fifo_cnt  <= 2'd0;
            r_data_loss <= 1'b0;
        end else begin
            if (w_pop) begin
                r_fifo[0] <= r_fifo[1];
            end
            if (w_push) begin
                r_fifo[w_wr_idx] <= {kb_is_mouse, kb_data};
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            r_data_loss <= kb_valid && w_fifo_full && !w_pop;
        end
    end

    // FSM state, selected source, offered packet and gap counter registers.
    always_ff @(posedge mon_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_sel      <= SRC_PWR;
            r_pkt_data <= 40'h0;
            r_gap_cnt  <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_sel      <= w_sel_next;
            r_pkt_data <= w_pkt_next;
            r_gap_cnt  <= w_gap_next;
        end
    end

    // Next-state logic: fixed-priority selection in IDLE, handshake in OFFER, countdown in GAP.
    always_comb begin
        w_next_state = r_state;
        w_sel_next   = r_sel;
        w_pkt_next   = r_pkt_data;
        w_gap_next   = r_gap_cnt;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pwr_pend) begin
                    w_sel_next   = SRC_PWR;
                    w_pkt_next   = {8'hC0, 32'h0};
                    w_next_state = ST_OFFER;
`ifdef OUT_ARB_AUDIO_REQ_EN
                end else if (r_aud_pend) begin
                    w_sel_next   = SRC_AUD;
                    w_pkt_next   = {8'h07, 32'h0};
                    w_next_state = ST_OFFER;
`endif
                end else if (!w_fifo_empty) begin
                    w_sel_next   = SRC_KB;
                    w_pkt_next   = w_kb_pkt;
                    w_next_state = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (pkt_if.pkt_ready) begin
                    w_done       = 1'b1;
                    w_pkt_next   = 40'h0;
                    w_gap_next   = LP_GAP;
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                w_gap_next = r_gap_cnt - 8'd1;
                if (r_gap_cnt <= 8'd1) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign pkt_if.pkt_valid = (r_state == ST_OFFER);
    assign pkt_if.pkt_data  = r_pkt_data;
    assign data_loss        = r_data_loss;
    assign busy             = (r_state != ST_IDLE);
    assign o_dbg_state      = r_state;

endmodule

// File: doc/out_packet_arbiter.md
OUT_PACKET_ARBITER -- requirements
Module: out_packet_arbiter

Interface
REQ-001 SHALL have parameter GAP, default 16, idle cycles enforced after each accepted packet (range 1..255).
REQ-002 SHALL have port mon_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port power_on_req  input  1  one-cycle pulse requesting the power-on reply packet.
REQ-005 SHALL have port kb_valid  input  1  one-cycle pulse; kb_data and kb_is_mouse are valid.
REQ-006 SHALL have port kb_is_mouse  input  1  1 = mouse event, 0 = keyboard event.
REQ-007 SHALL have port kb_data  input  16  keyboard/mouse payload.
REQ-008 SHALL have port audio_req_mode  input  1  level; audio sample requests are enabled.
REQ-009 SHALL have port audio_req_tick  input  1  one-cycle pulse requesting one audio sample packet.
REQ-010 SHALL have port pkt_ready  input  1  serial sender accepts a packet this cycle.
REQ-011 SHALL have port pkt_data  output  40  packet to the serial sender.
REQ-012 SHALL have port pkt_valid  output  1  pkt_data is offered.
REQ-013 SHALL have port data_loss  output  1  one-cycle pulse on a dropped keyboard/mouse event.
REQ-014 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 SHALL encode packets as: power-on {8'hC0, 32'h0}; audio request {8'h07, 32'h0}; keyboard {8'hDA, 16'h0, kb_data}; mouse {8'hDB, 16'h0, kb_data}.
REQ-016 SHALL hold a power-on pending flag, set by power_on_req; repeated pulses coalesce into one packet.
REQ-017 SHALL hold an audio pending flag, set by audio_req_tick only while audio_req_mode=1; ticks coalesce; audio_req_mode=0 clears the flag unless the audio packet is currently offered.
REQ-018 SHALL buffer keyboard/mouse events in a 2-entry FIFO, in order.
REQ-019 SHALL, on kb_valid with FIFO full and no pop that cycle, drop the new event and pulse data_loss for exactly one cycle; kb_valid simultaneous with a pop from a full FIFO SHALL be accepted without loss.
REQ-020 SHALL implement FSM states IDLE, OFFER, GAP.
REQ-021 SHALL, in IDLE with any request pending, select by fixed priority power-on > audio > FIFO head, load pkt_data, and enter OFFER; pkt_valid=1 exactly while in OFFER.
REQ-022 SHALL keep pkt_data and the selected source stable throughout OFFER, even if a higher-priority request arrives.
REQ-023 SHALL complete a transfer on any edge with pkt_valid=1 and pkt_ready=1: clear the selected pending flag or pop the FIFO, load the gap counter with GAP, and enter GAP.
REQ-024 SHALL, in GAP, decrement the counter each cycle and return to IDLE after exactly GAP cycles; requests arriving during OFFER/GAP stay pending.
REQ-025 SHALL, for a request captured at edge k with the FSM IDLE and nothing pending, raise pkt_valid after edge k+1.
REQ-026 SHALL drive pkt_data to 0 outside OFFER.

Reset
REQ-027 SHALL, on reset_n low at any time including mid-OFFER, immediately force: state IDLE, pkt_valid 0, pkt_data 0, data_loss 0, busy 0, all pending flags 0, FIFO empty, gap counter 0.
REQ-028 SHALL ignore all inputs while reset_n is low and resume normal operation on the first rising edge after release.

Configuration
REQ-029 SHALL compile audio request handling only when macro OUT_ARB_AUDIO_REQ_EN is defined.
REQ-030 SHALL, without OUT_ARB_AUDIO_REQ_EN, ignore audio_req_mode and audio_req_tick, never emit opcode 8'h07, and arbitrate power-on > FIFO head.

Verification
REQ-031 SHALL cover: power_on_req at edge 0, pkt_ready=1 -> pkt_valid after edge 1, pkt_data=40'hC0_0000_0000, accepted at edge 2, pkt_valid low for 16 cycles.
REQ-032 SHALL cover: three kb_valid pulses (0x0011, 0x0022, 0x0033) back-to-back with pkt_ready=0 -> third dropped, data_loss one-cycle pulse; releasing ready emits DA..0011 then DA..0022 only.
REQ-033 SHALL cover: mouse event 0x1234 and audio tick (mode=1) together while IDLE -> 07 packet first, then DB_0000_1234 after GAP.
REQ-034 SHALL cover: audio tick with mode=1, then mode=0 before selection (FSM in GAP) -> no 07 packet; with OUT_ARB_AUDIO_REQ_EN undefined any tick -> no 07 packet.
REQ-035 SHALL cover: reset_n asserted mid-OFFER with 2 FIFO entries pending -> pkt_valid 0 immediately; after release nothing is emitted without new requests.
